// File: rtl/dual_port_memory.sv
// -----------------------------------------------------------------------------
// dual_port_memory
//
// Dual-port word memory serving the core's instruction-fetch port (A) and its
// data-memory port (B). Both ports read synchronously with one cycle of
// latency. Port B writes under a per-bit, active-low write mask. When a port A
// read and a port B write hit the same word on the same edge, port A returns
// the word as it was before the write (read-first).
//
// Optional feature (compile-time macro DM_CLEAR_ON_RESET_EN):
//   defined   - a clear engine zeroes every word after reset. It runs for
//               exactly 2^AW cycles. `busy` is high while it runs. Port B
//               writes are ignored and both read outputs are held at zero
//               during the clear.
//   undefined - there is no clear engine. `busy` is tied low and array
//               contents are undefined until they are written.
//
// Parameters:
//   AW  word-address width (depth = 2^AW words)
//   DW  data width (only 32 is supported)
//
// Ports:
//   clk                 clock; all state updates on the rising edge
//   rst                 asynchronous, active-high reset
//   InstructionAddress  port A word address
//   instruction         port A read data (registered)
//   Data_address        port B word address
//   Write_enble         port B write strobe, active-low (0 = write)
//   Write_enble_bit     port B per-bit write mask, active-low (0 = write bit)
//   DataMemory_in       port B write data
//   DataMemory_out      port B read data (registered, holds on write cycles)
//   busy                high while the clear engine runs
// -----------------------------------------------------------------------------
module dual_port_memory #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] InstructionAddress,
    output logic [DW-1:0] instruction,
    input  logic [AW-1:0] Data_address,
    input  logic          Write_enble,
    input  logic [DW-1:0] Write_enble_bit,
    input  logic [DW-1:0] DataMemory_in,
    output logic [DW-1:0] DataMemory_out,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    // Storage array. It has no reset: clearing it is the clear engine's job.
    logic [DW-1:0] mem_r [DEPTH];

    // Asserted while the clear engine owns the array.
    logic          clearing_s;
    logic [AW-1:0] clr_addr_s;

    // Merges the write data into the old word wherever the active-low mask
    // bit is 0. All other bits keep their old value.
    function automatic logic [DW-1:0] merge_masked(
        input logic [DW-1:0] old_word,
        input logic [DW-1:0] new_word,
        input logic [DW-1:0] mask_n
    );
        return (old_word & mask_n) | (new_word & ~mask_n);
    endfunction

`ifdef DM_CLEAR_ON_RESET_EN

    localparam logic [0:0]    CLEAR     = 1'b0;
    localparam logic [0:0]    READY     = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [0:0]    state_r;
    logic [0:0]    state_nxt_s;
    logic [AW-1:0] clr_addr_r;
    logic [AW-1:0] clr_addr_nxt_s;
    logic          busy_r;

    // Next-state logic: sweep every address once, then settle in READY.
    always_comb begin
        state_nxt_s    = state_r;
        clr_addr_nxt_s = clr_addr_r;
        case (state_r)
            CLEAR: begin
                // The counter wraps to 0 on the same edge that clears the last word.
                clr_addr_nxt_s = clr_addr_r + ADDR_ONE;
                if (clr_addr_r == LAST_ADDR) begin
                    state_nxt_s = READY;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            READY: begin
                state_nxt_s = READY;
            end
            default: begin
                state_nxt_s    = CLEAR;
                clr_addr_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // State, clear counter and busy flag. Reset restarts the clear from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= CLEAR;
            clr_addr_r <= {AW{1'b0}};
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            clr_addr_r <= clr_addr_nxt_s;
            // busy tracks the next state, so it drops on the edge that clears the last word.
            busy_r     <= (state_nxt_s == CLEAR);
        end
    end

    assign clearing_s = (state_r == CLEAR);
    assign clr_addr_s = clr_addr_r;
    assign busy       = busy_r;

`else

    assign clearing_s = 1'b0;
    assign clr_addr_s = {AW{1'b0}};
    assign busy       = 1'b0;

`endif

    // Array write port: the clear engine, or a masked port B write. Writes are
    // suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing_s) begin
                mem_r[clr_addr_s] <= {DW{1'b0}};
            end else if (!Write_enble) begin
                mem_r[Data_address] <= merge_masked(mem_r[Data_address],
                                                    DataMemory_in,
                                                    Write_enble_bit);
            end
        end
    end

    // Registered read ports. Because these use non-blocking reads of the
    // array, a same-edge port B write is not visible yet (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction    <= {DW{1'b0}};
            DataMemory_out <= {DW{1'b0}};
        end else if (clearing_s) begin
            instruction    <= {DW{1'b0}};
            DataMemory_out <= {DW{1'b0}};
        end else begin
            instruction <= mem_r[InstructionAddress];
            // Port B output holds its previous value on write cycles.
            if (Write_enble) begin
                DataMemory_out <= mem_r[Data_address];
            end
        end
    end

endmodule

// File: tb/tb_dual_port_memory.sv
// -----------------------------------------------------------------------------
// tb_dual_port_memory
//
// Directed test of dual_port_memory with AW=4.
//
// The driver applies one vector per clock at the falling edge. For each vector
// it pushes the expected post-edge outputs into a queue. A monitor pops one
// entry after every rising edge and compares the DUT outputs with it.
//
// If DM_CLEAR_ON_RESET_EN is defined, the bench also covers the clear engine:
// the clear length, writes issued during the clear, and reset asserted
// mid-clear.
// -----------------------------------------------------------------------------
module tb_dual_port_memory;

    localparam int AW = 4;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] ZERO = 32'h0000_0000;
`ifdef DM_CLEAR_ON_RESET_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] InstructionAddress;
    logic [31:0]   instruction;
    logic [AW-1:0] Data_address;
    logic          Write_enble;
    logic [31:0]   Write_enble_bit;
    logic [31:0]   DataMemory_in;
    logic [31:0]   DataMemory_out;
    logic          busy;

    dual_port_memory #(.AW(AW), .DW(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .InstructionAddress (InstructionAddress),
        .instruction        (instruction),
        .Data_address       (Data_address),
        .Write_enble        (Write_enble),
        .Write_enble_bit    (Write_enble_bit),
        .DataMemory_in      (DataMemory_in),
        .DataMemory_out     (DataMemory_out),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          ca;
        logic [31:0] ea;
        bit          cb;
        logic [31:0] eb;
        bit          cy;
        bit          ey;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: one expected entry for each rising edge that had a driven vector.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.ca) chk("instr", mon_e.id, instruction, mon_e.ea);
            if (mon_e.cb) chk("dout", mon_e.id, DataMemory_out, mon_e.eb);
            if (mon_e.cy) chk("busy", mon_e.id, {31'b0, busy}, {31'b0, mon_e.ey});
        end
    end

    // Drives one vector (called at a falling edge), records the expected
    // outputs after the next rising edge, and returns at the following falling edge.
    task automatic step(input logic [AW-1:0] ia, input logic we_n, input logic [31:0] mask,
                        input logic [AW-1:0] da, input logic [31:0] din,
                        input bit ca, input logic [31:0] ea,
                        input bit cb, input logic [31:0] eb,
                        input bit cy, input bit ey);
        exp_t e;
        InstructionAddress = ia;
        Write_enble        = we_n;
        Write_enble_bit    = mask;
        Data_address       = da;
        DataMemory_in      = din;
        step_id++;
        e.id = step_id; e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb; e.cy = cy; e.ey = ey;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Clear-phase vectors k = 0..n-1 of a 16-cycle clear. Cycle 5 attempts a
    // write to address 3, which the clear engine has already zeroed.
    task automatic clear_steps(input int n);
        for (int k = 0; k < n; k++) begin
            step(AW'(k), (k == 5) ? 1'b0 : 1'b1, ZERO, (k == 5) ? 4'd3 : AW'(k), 32'h1234_5678,
                 1'b1, ZERO, 1'b1, ZERO, 1'b1, (k < 15));
        end
    endtask

    // Reads every word through both ports and expects zero.
    task automatic read_all_zero();
        for (int i = 0; i < 16; i++) begin
            step(AW'(i), 1'b1, ONES, AW'(i), ZERO, 1'b1, ZERO, 1'b1, ZERO, 1'b1, 1'b0);
        end
    endtask

    // Asserts reset between clock edges and checks that the outputs clear
    // immediately, then holds reset over two edges and releases it at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_instr", step_id, instruction, ZERO);
        chk("rst_dout", step_id, DataMemory_out, ZERO);
        chk("rst_busy", step_id, {31'b0, busy}, {31'b0, CLR_EN});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        InstructionAddress = '0;
        Data_address       = '0;
        Write_enble        = 1'b1;
        Write_enble_bit    = ONES;
        DataMemory_in      = ZERO;
        repeat (3) @(negedge clk);
        chk("reset_instr", 0, instruction, ZERO);
        chk("reset_dout", 0, DataMemory_out, ZERO);
        chk("reset_busy", 0, {31'b0, busy}, {31'b0, CLR_EN});
        rst = 1'b0;

`ifdef DM_CLEAR_ON_RESET_EN
        clear_steps(16);
        read_all_zero();
`endif

        // Full write; port A read-first returns the cleared word, and port B holds.
        step(4'd5, 1'b0, ZERO, 4'd5, 32'hDEAD_BEEF, CLR_EN, ZERO, 1'b1, ZERO, 1'b1, 1'b0);
        step(4'd5, 1'b1, ONES, 4'd5, ZERO, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        // Masked byte write: only bits 15:8 are taken from the write data.
        step(4'd5, 1'b0, 32'hFFFF_00FF, 4'd5, 32'h1122_3344, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step(4'd5, 1'b1, ONES, 4'd5, ZERO, 1'b1, 32'hDEAD_33EF, 1'b1, 32'hDEAD_33EF, 1'b1, 1'b0);
        // A write with an all-ones mask leaves the word unchanged.
        step(4'd5, 1'b0, ONES, 4'd5, ONES, 1'b1, 32'hDEAD_33EF, 1'b1, 32'hDEAD_33EF, 1'b1, 1'b0);
        step(4'd5, 1'b1, ONES, 4'd5, ZERO, 1'b1, 32'hDEAD_33EF, 1'b1, 32'hDEAD_33EF, 1'b1, 1'b0);
        // Collision at address 7: port A sees the old word, then the new one.
        step(4'd5, 1'b0, ZERO, 4'd7, 32'hAAAA_AAAA, 1'b1, 32'hDEAD_33EF, 1'b1, 32'hDEAD_33EF, 1'b1, 1'b0);
        step(4'd7, 1'b0, ZERO, 4'd7, 32'h5555_5555, 1'b1, 32'hAAAA_AAAA, 1'b1, 32'hDEAD_33EF, 1'b1, 1'b0);
        step(4'd7, 1'b1, ONES, 4'd7, ZERO, 1'b1, 32'h5555_5555, 1'b1, 32'h5555_5555, 1'b1, 1'b0);
        // Nibble-interleaved mask: high nibbles from the data, low nibbles kept.
        step(4'd5, 1'b0, 32'h0F0F_0F0F, 4'd7, 32'hF0F0_F0F0, 1'b1, 32'hDEAD_33EF, 1'b1, 32'h5555_5555, 1'b1, 1'b0);
        step(4'd7, 1'b1, ONES, 4'd7, ZERO, 1'b1, 32'hF5F5_F5F5, 1'b1, 32'hF5F5_F5F5, 1'b1, 1'b0);
        // Independent addresses on the two ports.
        step(4'd7, 1'b0, ZERO, 4'd0, 32'h0123_4567, 1'b1, 32'hF5F5_F5F5, 1'b1, 32'hF5F5_F5F5, 1'b1, 1'b0);
        step(4'd0, 1'b1, ONES, 4'd0, ZERO, 1'b1, 32'h0123_4567, 1'b1, 32'h0123_4567, 1'b1, 1'b0);

        // Reset while READY.
        do_reset();
`ifdef DM_CLEAR_ON_RESET_EN
        // A clear starts again; reset it at cycle 9, then expect a full 16-cycle clear.
        clear_steps(9);
        do_reset();
        clear_steps(16);
        read_all_zero();
`else
        // Without a clear engine the array keeps its contents across reset.
        step(4'd5, 1'b1, ONES, 4'd7, ZERO, 1'b1, 32'hDEAD_33EF, 1'b1, 32'hF5F5_F5F5, 1'b1, 1'b0);
        step(4'd0, 1'b1, ONES, 4'd5, ZERO, 1'b1, 32'h0123_4567, 1'b1, 32'hDEAD_33EF, 1'b1, 1'b0);
`endif

        chk("drain", step_id, exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_memory.md
# dual_port_memory

Dual-port word memory that answers the core's instruction-fetch and data-memory ports. Port A is a read-only fetch port fed by the core's instruction address. Port B is a read/write data port fed by the core's store/load path, with per-bit write masking. Both ports read synchronously with one-cycle latency, so an address presented in a core stage returns data in the following stage. An optional clear engine zeroes the array after reset.

## Interface
Parameters:
- `AW`, 14: word-address width; depth is 2^AW 32-bit words.
- `DW`, 32: data width. Only 32 is supported.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `InstructionAddress` input AW: port A word address.
- `instruction` output DW: port A read data.
- `Data_address` input AW: port B word address.
- `Write_enble` input 1: port B write strobe, active-low (0 = write cycle).
- `Write_enble_bit` input DW: per-bit write mask, active-low (0 = bit is written).
- `DataMemory_in` input DW: port B write data.
- `DataMemory_out` output DW: port B read data.
- `busy` output 1: high while the clear engine runs; the core is held in reset by the top level while `busy` is high.

## Operation
- Storage is a 2^AW x DW array, `mem`.
- Port A: on each edge, `instruction <= mem[InstructionAddress]`.
- Port B read: on each edge where `Write_enble` is 1, `DataMemory_out <= mem[Data_address]`.
- Port B write: on each edge where `Write_enble` is 0, update `mem[Data_address]` as follows:
  - each bit i takes `DataMemory_in[i]` if `Write_enble_bit[i]` is 0;
  - otherwise bit i keeps its old value.
- Port B write cycle: `DataMemory_out` holds its previous value; it is not updated.
- A write with an all-ones mask is a legal no-op write.
- Collision (port A read and port B write to the same address on the same edge): `instruction` returns the pre-write word (read-first). The new word is visible on the next edge.
- State machine, `state` in {CLEAR, READY}:
  - `rst` forces CLEAR when the clear feature is compiled in, otherwise READY.
  - CLEAR: writes `mem[clr_addr] <= 0` each edge, then `clr_addr <= clr_addr + 1`.
  - CLEAR to READY: after the edge that writes address 2^AW-1; `clr_addr` wraps to 0.
  - CLEAR: port B writes are ignored, and both read outputs are forced to 0.
  - READY: normal operation; no exit except `rst`.
- `clr_addr` is AW bits wide and resets to 0.

## Timing
- Output reset values: `instruction` = 0, `DataMemory_out` = 0, `busy` = 1 with the clear feature, 0 without it.
- Read latency is 1 cycle on both ports. Address at edge N gives data valid after edge N; there is no combinational path from address to data.
- Write latency: the written word is readable at edge N+1 through either port.
- Clear duration: exactly 2^AW cycles from the first edge after `rst` deasserts. `busy` falls after the edge that clears the last word.
- Reset asserted mid-clear: `busy` goes to 1 immediately (asynchronously) and `clr_addr` goes to 0. The clear restarts from address 0 after release.
- Reset asserted in READY: outputs go to their reset values immediately. Array contents are preserved unless a clear runs.

## Configuration
- `DM_CLEAR_ON_RESET_EN` defined:
  - the clear engine is present;
  - reset enters CLEAR, and `busy` behaves as described above.
- `DM_CLEAR_ON_RESET_EN` undefined:
  - the clear engine and its counter are removed;
  - `busy` is tied to 0 and reset enters READY directly;
  - array contents are undefined until written or preloaded by the bench.

## Test plan
- Clear (macro on, AW=4): release `rst` → `busy` is 1 for exactly 16 cycles, then 0; reads of addresses 0-15 return 0x00000000.
- Full write/read: `Write_enble`=0, mask 0x00000000, address 5, data 0xDEADBEEF → next cycle `Write_enble`=1, address 5 → `DataMemory_out`=0xDEADBEEF one cycle later; `instruction` with address 5 also returns 0xDEADBEEF.
- Masked byte write: preload address 5 = 0xDEADBEEF; write 0x11223344 with mask 0xFFFF00FF → read returns 0xDEAD33EF.
- Collision: address 7 holds 0xAAAAAAAA; same edge: port B writes 0x55555555 to 7 and port A reads 7 → `instruction`=0xAAAAAAAA, then 0x55555555 on the next edge.
- Write during CLEAR: write 0x12345678 to address 3 while `busy`=1 → after clear, address 3 reads 0; outputs stay 0 throughout CLEAR.
- Reset mid-clear (AW=4): assert `rst` at clear cycle 9 and release → `busy` stays high for 16 more cycles; all 16 words read 0.
